// File: rtl/dvp_timing_gen.sv
// DVP camera source model: parametrised VSYNC/HREF frame timing with
// NCH pattern-generated 8-bit data lanes, frame limit and clean stop.
module dvp_timing_gen #(
  parameter int NCH        = 2,
  parameter int H_ACT      = 1280,
  parameter int BPP        = 2,
  parameter int H_BLK      = 1408,
  parameter int V_ACT      = 720,
  parameter int VS_W       = 176,
  parameter int VBP        = 12176,
  parameter int VFP        = 1000,
  parameter int NUM_FRAMES = 0,
  parameter int LANE_OFS   = 64
) (
  input  logic            pclk,
  input  logic            reset_n,
  input  logic            run_test,
  input  logic            stop_test,
  input  logic [1:0]      pattern_sel,
  output logic            VSYNC,
  output logic            HREF,
  output logic [NCH*8-1:0] D,
  output logic [15:0]     frame_cnt,
  output logic            busy
);

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int ACT_LEN = H_ACT * BPP;
  localparam int MAXD    = max2(max2(max2(VS_W, VBP), max2(ACT_LEN, H_BLK)), VFP);
  localparam int CW      = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int LW      = (V_ACT > 1) ? $clog2(V_ACT) : 1;

  localparam logic [CW-1:0] VS_LAST   = CW'(VS_W - 1);
  localparam logic [CW-1:0] VBP_LAST  = CW'(VBP - 1);
  localparam logic [CW-1:0] ACT_LAST  = CW'(ACT_LEN - 1);
  localparam logic [CW-1:0] HBLK_LAST = CW'(H_BLK - 1);
  localparam logic [CW-1:0] VFP_LAST  = CW'(VFP - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(V_ACT - 1);

  typedef enum logic [2:0] {S_IDLE, S_VS, S_VBP, S_ACT, S_HBLK, S_VFP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [LW-1:0]   line, line_nxt;
  logic            frame_end;
  logic            stop_pend;
  logic [1:0]      pat;
  logic [15:0]     fc_inc;
  logic [7:0]      b8, l8;
  logic [NCH*8-1:0] d_nxt;

  assign fc_inc = (frame_cnt == 16'hFFFF) ? frame_cnt : frame_cnt + 16'd1;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      line  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      line  <= line_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    line_nxt  = line;
    frame_end = 1'b0;
    case (state)
      S_IDLE: if (run_test) state_nxt = S_VS;
      S_VS:   if (cnt == VS_LAST) state_nxt = S_VBP;
      S_VBP:  if (cnt == VBP_LAST) state_nxt = S_ACT;
      S_ACT:  if (cnt == ACT_LAST) state_nxt = S_HBLK;
      S_HBLK: begin
        if (cnt == HBLK_LAST) begin
          if (line < LINE_LAST) begin
            state_nxt = S_ACT;
            line_nxt  = line + LW'(1);
          end else begin
            state_nxt = S_VFP;
          end
        end
      end
      S_VFP: begin
        if (cnt == VFP_LAST) begin
          frame_end = 1'b1;
          if (stop_pend || (NUM_FRAMES != 0 && fc_inc == 16'(NUM_FRAMES)))
            state_nxt = S_IDLE;
          else
            state_nxt = S_VS;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt != state || state == S_IDLE) cnt_nxt = '0;
    if (state_nxt == S_VS && state != S_VS) line_nxt = '0;
  end

  // Outputs are registered from the next-state view so they line up with the FSM.
  assign b8 = 8'(cnt_nxt);
  assign l8 = 8'(line_nxt);

  always_comb begin
    d_nxt = '0;
    if (state_nxt == S_ACT) begin
      for (int n = 0; n < NCH; n++) begin
        case (pat)
          2'd0:    d_nxt[8*n +: 8] = b8 + 8'(n * LANE_OFS);
          2'd1:    d_nxt[8*n +: 8] = l8;
          2'd2:    d_nxt[8*n +: 8] = frame_cnt[7:0];
          default: d_nxt[8*n +: 8] = (b8[3] ^ l8[3]) ? 8'hFF : 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      VSYNC     <= 1'b0;
      HREF      <= 1'b0;
      busy      <= 1'b0;
      D         <= '0;
      frame_cnt <= '0;
      pat       <= '0;
      stop_pend <= 1'b0;
    end else begin
      VSYNC <= (state_nxt == S_VS);
      HREF  <= (state_nxt == S_ACT);
      busy  <= (state_nxt != S_IDLE);
      D     <= d_nxt;
      if (state == S_IDLE && run_test)
        frame_cnt <= '0;
      else if (frame_end)
        frame_cnt <= fc_inc;
      if (state_nxt == S_VS && state != S_VS)
        pat <= pattern_sel;
      // A stop request only ever ends a run at a frame boundary.
      if (state_nxt == S_IDLE)
        stop_pend <= 1'b0;
      else if (stop_test)
        stop_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dvp_timing_gen.sv
// Scoreboard bench for dvp_timing_gen on the small 26-cycle-frame config:
// one single-frame instance and one continuous instance.
module tb_dvp_timing_gen;

  logic pclk = 1'b0;
  logic reset_n;
  logic run_s, stop_s, run_c, stop_c;
  logic [1:0] pattern_sel;
  logic s_vs, s_href, s_busy, c_vs, c_href, c_busy;
  logic [15:0] s_d, c_d, s_fc, c_fc;
  logic mon_sel, m_href, m_busy;
  logic [15:0] m_d;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [15:0] expq[$];

  always #5 pclk = ~pclk;

  dvp_timing_gen #(.NCH(2), .H_ACT(4), .BPP(2), .H_BLK(3), .V_ACT(2), .VS_W(2),
                   .VBP(1), .VFP(1), .NUM_FRAMES(1), .LANE_OFS(64)) dut_s (
    .pclk(pclk), .reset_n(reset_n), .run_test(run_s), .stop_test(stop_s),
    .pattern_sel(pattern_sel), .VSYNC(s_vs), .HREF(s_href), .D(s_d),
    .frame_cnt(s_fc), .busy(s_busy));

  dvp_timing_gen #(.NCH(2), .H_ACT(4), .BPP(2), .H_BLK(3), .V_ACT(2), .VS_W(2),
                   .VBP(1), .VFP(1), .NUM_FRAMES(0), .LANE_OFS(64)) dut_c (
    .pclk(pclk), .reset_n(reset_n), .run_test(run_c), .stop_test(stop_c),
    .pattern_sel(pattern_sel), .VSYNC(c_vs), .HREF(c_href), .D(c_d),
    .frame_cnt(c_fc), .busy(c_busy));

  assign m_href = mon_sel ? c_href : s_href;
  assign m_busy = mon_sel ? c_busy : s_busy;
  assign m_d    = mon_sel ? c_d : s_d;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Expected lane words of one 2x8-byte frame; lane1 in the upper byte.
  task automatic pushFrame(input int p, input int fnum);
    logic [7:0] ln [2];
    for (int l = 0; l < 2; l++)
      for (int b = 0; b < 8; b++) begin
        for (int n = 0; n < 2; n++)
          case (p)
            0:       ln[n] = 8'(b + n * 64);
            1:       ln[n] = 8'(l);
            2:       ln[n] = 8'(fnum);
            default: ln[n] = (((b >> 3) ^ (l >> 3)) & 1) != 0 ? 8'hFF : 8'h00;
          endcase
        expq.push_back({ln[1], ln[0]});
      end
  endtask

  task automatic startTest();
    @(posedge pclk);
    #1;
    cyc = 0;
  endtask

  task automatic toCycle(input int n);
    repeat (n - cyc) @(posedge pclk);
    #1;
    cyc = n;
  endtask

  // Monitor: each HREF cycle consumes one expected word; D must idle low otherwise.
  always @(negedge pclk) begin
    if (reset_n) begin
      if (m_href) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected HREF beat", 32'(m_d), 32'hDEAD);
        end else begin
          checkOutput("data beat", 32'(m_d), 32'(expq.pop_front()));
        end
      end else if (m_busy) begin
        checkOutput("D idle during blanking", 32'(m_d), 32'h0);
      end
    end
  end

  task automatic applyStimulus();
    // Reset state
    reset_n = 1'b0; run_s = 0; stop_s = 0; run_c = 0; stop_c = 0;
    pattern_sel = 2'd0; mon_sel = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    checkOutput("reset single", {s_vs, s_href, s_busy, s_d, s_fc}, 35'h0);
    checkOutput("reset cont", {c_vs, c_href, c_busy, c_d, c_fc}, 35'h0);
    reset_n = 1'b1;

    // Single frame, ramp data, NUM_FRAMES=1
    startTest();
    pushFrame(0, 0);
    run_s = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      toCycle(c);
      if (c == 1) run_s = 1'b0;
      checkOutput($sformatf("single trace c%0d", c), {s_vs, s_href, s_busy},
                  {c <= 2, (c >= 4 && c <= 11) || (c >= 15 && c <= 22), c <= 26});
      if (c == 26) checkOutput("single fc before end", s_fc, 16'd0);
      if (c == 27) checkOutput("single fc after end", s_fc, 16'd1);
    end
    checkOutput("single queue drained", expq.size(), 0);

    // Continuous run with ignored run_test and stop in frame 3
    mon_sel = 1'b1;
    pattern_sel = 2'd1;
    startTest();
    pushFrame(1, 0); pushFrame(1, 1); pushFrame(1, 2);
    run_c = 1'b1;
    toCycle(1);  run_c = 1'b0;
    toCycle(27); checkOutput("cont fc frame1", c_fc, 16'd1);
    toCycle(30); run_c = 1'b1;
    toCycle(31); run_c = 1'b0;
    toCycle(53); checkOutput("cont fc frame2", c_fc, 16'd2);
    checkOutput("cont vsync frame3", c_vs, 1'b1);
    toCycle(58); stop_c = 1'b1;
    toCycle(59); stop_c = 1'b0;
    toCycle(78); checkOutput("cont busy last cycle", c_busy, 1'b1);
    toCycle(79); checkOutput("cont busy fall", c_busy, 1'b0);
    checkOutput("cont fc final", c_fc, 16'd3);
    toCycle(90); checkOutput("cont stays idle", {c_vs, c_busy}, 2'b00);
    checkOutput("cont queue drained", expq.size(), 0);

    // Pattern switch mid-frame applies at next VSYNC rise
    pattern_sel = 2'd0;
    startTest();
    pushFrame(0, 0); pushFrame(2, 1);
    run_c = 1'b1;
    toCycle(1);  run_c = 1'b0;
    toCycle(10); pattern_sel = 2'd2;
    toCycle(30); stop_c = 1'b1;
    toCycle(31); stop_c = 1'b0;
    toCycle(52); checkOutput("switch busy frame2", c_busy, 1'b1);
    toCycle(53); checkOutput("switch end", {c_busy, c_fc}, {1'b0, 16'd2});
    checkOutput("switch queue drained", expq.size(), 0);

    // Reset during frame 2 active line
    pattern_sel = 2'd3;
    startTest();
    pushFrame(3, 0);
    expq.push_back(16'h0000); expq.push_back(16'h0000);
    run_c = 1'b1;
    toCycle(1);  run_c = 1'b0;
    toCycle(32);
    checkOutput("pre-reset active", {c_href, c_fc}, {1'b1, 16'd1});
    reset_n = 1'b0;
    #1;
    checkOutput("async reset", {c_vs, c_href, c_busy, c_d, c_fc}, 35'h0);
    toCycle(34); reset_n = 1'b1;
    toCycle(44); checkOutput("idle after reset", {c_vs, c_href, c_busy}, 3'b000);
    checkOutput("reset queue drained", expq.size(), 0);

    // run_test with stop_test in IDLE: exactly one frame
    pattern_sel = 2'd1;
    startTest();
    pushFrame(1, 0);
    run_c = 1'b1; stop_c = 1'b1;
    toCycle(1);  run_c = 1'b0; stop_c = 1'b0;
    checkOutput("one-shot start", {c_vs, c_busy}, 2'b11);
    toCycle(26); checkOutput("one-shot busy", c_busy, 1'b1);
    toCycle(27); checkOutput("one-shot end", {c_vs, c_busy, c_fc}, {2'b00, 16'd1});
    toCycle(35); checkOutput("one-shot idle", c_busy, 1'b0);
    checkOutput("one-shot queue drained", expq.size(), 0);
  endtask

  initial begin
    applyStimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
